// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer that does every addition on a shared
// external Hack ALU; returns the low WIDTH bits of a*b.
module alu_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             product_zr,
  output logic             product_ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [5:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0]       CTL_ZERO  = 6'b101010;
  localparam logic [5:0]       CTL_ADD   = 6'b000010;
  localparam logic [5:0]       CTL_PASSX = 6'b001100;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             product_zr_q, product_zr_d;
  logic             product_ng_q, product_ng_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // The ALU is idled at constant 0 outside RUN so it never sees stale operands.
  always_comb begin
    alu_ctl = CTL_ZERO;
    alu_x   = '0;
    alu_y   = '0;
    if (state_q == RUN) begin
      alu_x   = acc_q;
      alu_y   = mcand_q;
      alu_ctl = mplier_q[0] ? CTL_ADD : CTL_PASSX;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    product_d    = product_q;
    product_zr_d = product_zr_q;
    product_ng_d = product_ng_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = '0;
          state_d  = RUN;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        acc_d    = alu_out;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Stop early once no multiplier bits remain; this ALU result is final.
        if ((mplier_q >> 1) == '0 || cnt_q == LAST_CNT) begin
          product_d    = alu_out;
          product_zr_d = alu_zr;
          product_ng_d = alu_ng;
          state_d      = DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      product_q    <= '0;
      product_zr_q <= 1'b0;
      product_ng_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
      product_q    <= product_d;
      product_zr_q <= product_zr_d;
      product_ng_q <= product_ng_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign product    = product_q;
  assign product_zr = product_zr_q;
  assign product_ng = product_ng_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: a behavioural Hack ALU closes the loop,
// directed vectors push hand-computed results, a monitor checks each done.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a_in, b_in;
  logic        busy, done;
  logic [15:0] product;
  logic        product_zr, product_ng;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_ctl;
  logic        alu_zr, alu_ng;

  int n_cmp  = 0;
  int n_fail = 0;
  int cycle_cnt = 0;

  typedef struct {
    logic [15:0] prod;
    logic        zr;
    logic        ng;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  alu_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in),
    .busy(busy), .done(done), .product(product),
    .product_zr(product_zr), .product_ng(product_ng),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Hack ALU, ctl = {zx,nx,zy,ny,f,no}
  logic [15:0] hx1, hx2, hy1, hy2, hf;
  always_comb begin
    hx1     = alu_ctl[5] ? 16'h0000 : alu_x;
    hx2     = alu_ctl[4] ? ~hx1 : hx1;
    hy1     = alu_ctl[3] ? 16'h0000 : alu_y;
    hy2     = alu_ctl[2] ? ~hy1 : hy1;
    hf      = alu_ctl[1] ? (hx2 + hy2) : (hx2 & hy2);
    alu_out = alu_ctl[0] ? ~hf : hf;
    alu_zr  = (alu_out == 16'h0000);
    alu_ng  = alu_out[15];
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, expv, cycle_cnt);
    end
  endtask

  task automatic pushExp(input logic [15:0] p, input logic z, input logic n,
                         input int t0, input int lat);
    exp_t t;
    t.prod = p; t.zr = z; t.ng = n; t.t0 = t0; t.lat = lat;
    sb.push_back(t);
  endtask

  task automatic waitDone(input string name);
    int t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got no done after %0d cycles expected done", name, t);
    end
  endtask

  // Latency is measured from the cycle start is driven to the cycle done is high.
  task automatic applyStimulus(input string name, input logic [15:0] av,
                               input logic [15:0] bv, input logic [15:0] ep,
                               input logic ez, input logic en, input int lat,
                               input int ctl_n, input logic [5:0] c0,
                               input logic [5:0] c1);
    @(negedge clk);
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    pushExp(ep, ez, en, cycle_cnt, lat);
    @(negedge clk);
    start = 1'b0;
    a_in  = 16'hA5A5;
    b_in  = 16'h5A5A;
    for (int i = 0; i < ctl_n; i++) begin
      checkOutput({name, "_ctl"}, {26'd0, alu_ctl}, {26'd0, (i == 0) ? c0 : c1});
      if (i + 1 < ctl_n) @(negedge clk);
    end
    waitDone(name);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_e = sb.pop_front();
        checkOutput("product", {16'd0, product}, {16'd0, mon_e.prod});
        checkOutput("product_zr", {31'd0, product_zr}, {31'd0, mon_e.zr});
        checkOutput("product_ng", {31'd0, product_ng}, {31'd0, mon_e.ng});
        checkOutput("latency", cycle_cnt - mon_e.t0, mon_e.lat);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = 16'd0;
    b_in  = 16'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_product", {16'd0, product}, 32'd0);
    checkOutput("rst_flags", {30'd0, product_zr, product_ng}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ctl", {26'd0, alu_ctl}, 32'b101010);
    checkOutput("idle_xy", {alu_x, alu_y}, 32'd0);

    applyStimulus("m100x3", 16'd100, 16'd3, 16'd300, 1'b0, 1'b0, 3, 2, 6'b000010, 6'b000010);
    applyStimulus("m100x0", 16'd100, 16'd0, 16'd0, 1'b1, 1'b0, 2, 1, 6'b001100, 6'b001100);
    applyStimulus("mneg1x3", 16'hFFFF, 16'd3, 16'hFFFD, 1'b0, 1'b1, 3, 2, 6'b000010, 6'b000010);
    applyStimulus("m1x8000", 16'd1, 16'h8000, 16'h8000, 1'b0, 1'b1, 17, 1, 6'b001100, 6'b001100);
    applyStimulus("mwrap", 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 10, 0, 6'b0, 6'b0);

    // start held high: 7*5 twice, second accepted straight from DONE
    @(negedge clk);
    a_in  = 16'd7;
    b_in  = 16'd5;
    start = 1'b1;
    c = cycle_cnt;
    pushExp(16'd35, 1'b0, 1'b0, c, 4);
    pushExp(16'd35, 1'b0, 1'b0, c + 4, 4);
    repeat (5) @(negedge clk);
    start = 1'b0;
    waitDone("held");

    // start re-asserted mid-RUN is ignored; 5*5 then starts from DONE
    @(negedge clk);
    a_in  = 16'd9;
    b_in  = 16'd6;
    start = 1'b1;
    c = cycle_cnt;
    pushExp(16'd54, 1'b0, 1'b0, c, 4);
    @(negedge clk);
    a_in  = 16'd2;
    b_in  = 16'd2;
    @(negedge clk);
    checkOutput("run_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    a_in = 16'd5;
    b_in = 16'd5;
    pushExp(16'd25, 1'b0, 1'b0, c + 4, 4);
    repeat (2) @(negedge clk);
    start = 1'b0;
    waitDone("b2b");
    repeat (3) @(negedge clk);
    checkOutput("hold_product", {16'd0, product}, 32'd25);

    // reset during the 2nd RUN cycle abandons the operation
    a_in  = 16'd9;
    b_in  = 16'd255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_product", {16'd0, product}, 32'd0);
    checkOutput("abort_ctl", {26'd0, alu_ctl}, 32'b101010);
    repeat (12) @(negedge clk);
    applyStimulus("m9x255", 16'd9, 16'd255, 16'd2295, 1'b0, 1'b0, 9, 2, 6'b000010, 6'b000010);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle shift-and-add multiplier sequencer that performs every addition on a shared external 16-bit Hack ALU (zx,nx,zy,ny,f,no control set).
- Drives the ALU operands and the 6 control bits, and consumes the ALU's out/zr/ng outputs in the same cycle.
- Returns the low 16 bits of a*b. This value is identical for signed and unsigned operands in two's complement.
- Sits beside ALU16 in the CPU datapath as the sequencer for a future MUL instruction.

Parameters:
- WIDTH, 16, operand/product/ALU word width.
- CNT_W, 5, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  multiplicand; captured when start is accepted.
- b  in  WIDTH  multiplier; captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the product becomes valid.
- product  out  WIDTH  result register; held until the next accepted start.
- product_zr  out  1  product==0, captured with product.
- product_ng  out  1  product[WIDTH-1], captured with product.
- alu_x  out  WIDTH  ALU x operand.
- alu_y  out  WIDTH  ALU y operand.
- alu_ctl  out  6  {zx,nx,zy,ny,f,no}.
- alu_out  in  WIDTH  ALU result; combinational, same cycle.
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.

Behaviour:
- Reset: synchronous, active-low, on the rising edge of clk when rst_n=0. All registers clear; state=IDLE; busy=0, done=0, product=0, product_zr=0, product_ng=0. Reset has priority over every other event, including in RUN: the operation is abandoned and no done pulse is issued.
- State register holds IDLE, RUN or DONE. Internal registers: acc, mcand, mplier (all WIDTH bits) and cnt (CNT_W bits).
- IDLE:
  - alu_ctl=101010 (constant 0), alu_x=alu_y=0.
  - If start=1: acc<=0, mcand<=a, mplier<=b, cnt<=0, go to RUN.
- RUN (busy=1), one iteration per cycle:
  - If mplier[0]=1: alu_ctl=000010 (x+y), alu_x=acc, alu_y=mcand.
  - Else: alu_ctl=001100 (x passes through), alu_x=acc, alu_y=mcand.
  - Every cycle: acc<=alu_out, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - The ALU sum wraps modulo 2^WIDTH; carries beyond WIDTH are discarded.
  - Exit when (mplier>>1)==0 or cnt==WIDTH-1. Then: product<=alu_out, product_zr<=alu_zr, product_ng<=alu_ng, go to DONE.
- Iteration count n = max(1, index of the highest set bit of b, plus 1). b=0 takes exactly 1 iteration and produces 0.
- Latency: start is sampled high on edge E. RUN occupies the n cycles after E. done=1 during the cycle after the last RUN cycle, i.e. n+1 cycles after E.
- DONE:
  - done=1, busy=0, ALU outputs as in IDLE.
  - If start=1, the new operands are captured and the next state is RUN (back-to-back operation with no IDLE gap). Otherwise the next state is IDLE.
- start is ignored while in RUN: operands are not re-sampled and there is no error indication.
- a and b may change freely after capture without affecting the result.
- product, product_zr and product_ng change only on the exit transition or on reset.

Test Plan:
- a=100, b=3, start pulsed once -> RUN for 2 cycles with alu_ctl sequence 000010, 000010; done 3 cycles after start; product=300, zr=0, ng=0.
- a=100, b=0 -> 1 RUN cycle with alu_ctl=001100; done 2 cycles after start; product=0, zr=1, ng=0.
- a=16'hFFFF (-1), b=3 -> product=16'hFFFD (-3), ng=1, done 3 cycles after start.
- a=1, b=16'h8000 -> 16 RUN cycles, done 17 cycles after start, product=16'h8000, ng=1. Then a=16'h0100, b=16'h0100 -> product=0 (wrap), zr=1.
- start held high continuously with a=7, b=5 -> product 35. start re-asserted mid-RUN with different operands is ignored; after done the next operation starts directly from DONE.
- rst_n=0 for one cycle during the 2nd RUN cycle of a=9, b=255 -> next cycle state=IDLE, busy=0, no done pulse, product=0. A fresh start then produces 2295 after 9 cycles.
